// File: rtl/vga_pkg.sv
// Shared VGA timing package: vertical FSM state type plus the default
// 640x480@60 horizontal (hsync_cnt) and vertical (vsync_cnt) timing constants.
package vga_pkg;

    typedef enum logic [1:0] {
        VISIBLE = 2'd0,
        FRONT   = 2'd1,
        SYNC    = 2'd2,
        BACK    = 2'd3
    } vstate_t;

    // Horizontal timing, consumed by hsync_cnt
    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;

    // Vertical timing, consumed by vsync_cnt
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int ROW_W     = 11;
    localparam int FRAME_W   = 8;

endpackage : vga_pkg

// File: rtl/vsync_cnt_if.sv
// Bus between hsync_cnt/display logic and vsync_cnt.
// Optional macro FRAME_CNT_EN adds the frame_cnt signal and its FRAME_W parameter.
interface vsync_cnt_if #(
    parameter int ROW_W   = 11
`ifdef FRAME_CNT_EN
   ,parameter int FRAME_W = 8
`endif
);

    logic             line_done;
    logic             vsync;
    logic             rgb_en;
    logic [ROW_W-1:0] row;
    logic             frame_end;
`ifdef FRAME_CNT_EN
    logic [FRAME_W-1:0] frame_cnt;
`endif

`ifdef FRAME_CNT_EN
    modport master (output line_done,
                    input  vsync, rgb_en, row, frame_end, frame_cnt);
    modport slave  (input  line_done,
                    output vsync, rgb_en, row, frame_end, frame_cnt);
`else
    modport master (output line_done,
                    input  vsync, rgb_en, row, frame_end);
    modport slave  (input  line_done,
                    output vsync, rgb_en, row, frame_end);
`endif

endinterface : vsync_cnt_if

// File: rtl/vsync_cnt.sv
// Vertical timing generator. Counts lines on each line_done cycle through
// VISIBLE -> FRONT -> SYNC -> BACK and produces registered vsync (active low),
// rgb_en, row and a one-cycle frame_end on wrap.
// Optional macro FRAME_CNT_EN adds a FRAME_W-bit wrapping frame counter.
module vsync_cnt
    import vga_pkg::*;
#(
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_pkg::V_FRONT,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BACK    = vga_pkg::V_BACK,
    parameter int ROW_W     = vga_pkg::ROW_W
`ifdef FRAME_CNT_EN
   ,parameter int FRAME_W   = vga_pkg::FRAME_W
`endif
) (
    input  logic        clk,
    input  logic        rst,
    vsync_cnt_if.slave  bus
);

    localparam int      V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam longint  ROW_SPAN = 64'd1 << ROW_W;

    // Last row index of each region; the FSM leaves a region on these rows
    localparam logic [ROW_W-1:0] VIS_LAST   = ROW_W'(V_VISIBLE - 1);
    localparam logic [ROW_W-1:0] FRONT_LAST = ROW_W'(V_VISIBLE + V_FRONT - 1);
    localparam logic [ROW_W-1:0] SYNC_LAST  = ROW_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(V_TOTAL - 1);
    localparam logic [ROW_W-1:0] ROW_ONE    = ROW_W'(1);

    // Reject timing that cannot be represented or has an empty region
    if ((V_VISIBLE < 1) || (V_FRONT < 1) || (V_SYNC < 1) || (V_BACK < 1)) begin : g_err_region
        $error("vsync_cnt: every vertical region must be at least one line");
    end
    if (longint'(V_TOTAL) > ROW_SPAN) begin : g_err_width
        $error("vsync_cnt: V_TOTAL does not fit in ROW_W bits");
    end
`ifdef FRAME_CNT_EN
    if (FRAME_W < 1) begin : g_err_frame
        $error("vsync_cnt: FRAME_W must be at least 1");
    end
`endif

    vstate_t          state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             vsync_q, vsync_d;
    logic             rgb_en_q, rgb_en_d;
    logic             frame_end_q, frame_end_d;

    // Next-state: advance one line per line_done cycle, step FSM at region ends
    always_comb begin
        row_d       = row_q;
        state_d     = state_q;
        frame_end_d = 1'b0;
        if (bus.line_done) begin
            if (row_q == LAST_ROW) begin
                row_d       = '0;
                frame_end_d = 1'b1;
            end else begin
                row_d       = row_q + ROW_ONE;
                frame_end_d = 1'b0;
            end
            case (state_q)
                VISIBLE: begin
                    if (row_q == VIS_LAST) state_d = FRONT;
                    else                   state_d = VISIBLE;
                end
                FRONT: begin
                    if (row_q == FRONT_LAST) state_d = SYNC;
                    else                     state_d = FRONT;
                end
                SYNC: begin
                    if (row_q == SYNC_LAST) state_d = BACK;
                    else                    state_d = SYNC;
                end
                BACK: begin
                    if (row_q == LAST_ROW) state_d = VISIBLE;
                    else                   state_d = BACK;
                end
                default: state_d = VISIBLE;
            endcase
        end else begin
            row_d   = row_q;
            state_d = state_q;
        end
        // Decoded from the next state so the registered flags line up with row
        vsync_d  = (state_d != SYNC);
        rgb_en_d = (state_d == VISIBLE);
    end

    // Timing registers with synchronous reset taking priority over line_done
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= VISIBLE;
            row_q       <= '0;
            vsync_q     <= 1'b1;
            rgb_en_q    <= 1'b1;
            frame_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            vsync_q     <= vsync_d;
            rgb_en_q    <= rgb_en_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign bus.row       = row_q;
    assign bus.vsync     = vsync_q;
    assign bus.rgb_en    = rgb_en_q;
    assign bus.frame_end = frame_end_q;

`ifdef FRAME_CNT_EN
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

    // Frame counter next value: bump on every wrap, natural modulo 2**FRAME_W
    always_comb begin
        if (frame_end_d) begin
            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Frame counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule : vsync_cnt
